// File: rtl/pong_graphics_pkg.sv
// Shared constants for the Pong pixel-generation stage: screen geometry,
// colour palette and reset positions of the paddle and ball.
package pong_pkg;

    localparam int unsigned PIX_W    = 10;
    localparam int unsigned RGB_W    = 12;

    localparam int unsigned H_VIS    = 640;
    localparam int unsigned V_VIS    = 480;
    localparam int unsigned REFR_ROW = 481;

    localparam logic [RGB_W-1:0] COL_WALL = 12'h00F;
    localparam logic [RGB_W-1:0] COL_PAD  = 12'h0F0;
    localparam logic [RGB_W-1:0] COL_BALL = 12'hF00;
    localparam logic [RGB_W-1:0] COL_BG   = 12'h888;
    localparam logic [RGB_W-1:0] COL_OFF  = 12'h000;

    localparam logic [PIX_W-1:0] PAD_TOP_RST = 10'd204;
    localparam logic [PIX_W-1:0] BALL_X_RST  = 10'd320;
    localparam logic [PIX_W-1:0] BALL_Y_RST  = 10'd240;

endpackage

// File: rtl/pong_graphics_frame_tick_gen.sv
// Once-per-frame refresh tick.
// Ports: clk, reset (async, active-low), pixel_x/pixel_y (scan position),
//        refr_tick (1-clk pulse on the first clk at row 481, column 0).
module frame_tick_gen
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_x,
    input  logic [PIX_W-1:0] pixel_y,
    output logic             refr_tick
);

    logic match_d;
    logic match_q;

    // Scan position sits on the refresh point; it dwells several clks there.
    always_comb begin
        match_d = (pixel_y == PIX_W'(REFR_ROW)) && (pixel_x == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    // Rising edge of the match so the dwell yields a single pulse.
    assign refr_tick = match_d & ~match_q;

endmodule

// File: rtl/pong_graphics.sv
// Pong pixel generator: wall, right paddle and bouncing ball, with
// frame-rate game state and a 1-clk registered RGB/sync pipeline.
// Ports: clk, reset (async, active-low), pixel_x/pixel_y/video_on and
//        hsync_in/vsync_in from the sync stage, btn ({up,down});
//        rgb, hsync_out, vsync_out (all 1-clk delayed), miss_tick, miss_cnt.
// Build option: define PONG_MISS_CNT_EN for a saturating miss counter;
//        otherwise miss_cnt is constant zero.
module pong_graphics
    import pong_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned BALL_V    = 2,
    parameter int unsigned PAD_H     = 72,
    parameter int unsigned PAD_V     = 4,
    parameter int unsigned PAD_X_L   = 600,
    parameter int unsigned WALL_X_L  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pixel_x,
    input  logic [PIX_W-1:0]  pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        btn,
    output logic [RGB_W-1:0]  rgb,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              miss_tick,
    output logic [3:0]        miss_cnt
);

    localparam logic [PIX_W-1:0] BV_POS = PIX_W'(BALL_V);
    localparam logic [PIX_W-1:0] BV_NEG = ~BV_POS + 10'd1;

    logic             refr_tick;
    logic [PIX_W-1:0] pad_top_q, pad_top_d;
    logic [PIX_W-1:0] ball_x_q, ball_x_d;
    logic [PIX_W-1:0] ball_y_q, ball_y_d;
    logic [PIX_W-1:0] dx_q, dx_d;
    logic [PIX_W-1:0] dy_q, dy_d;
    logic             miss_tick_q, miss_tick_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, vsync_q;
    logic             wall_on, pad_on, ball_on, pad_hit;

    frame_tick_gen u_tick (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .refr_tick (refr_tick)
    );

    // Ball's right edge inside paddle columns, rows overlapping, moving right.
    always_comb begin
        pad_hit = (ball_x_q + PIX_W'(BALL_SIZE - 1) >= PIX_W'(PAD_X_L))
               && (ball_x_q + PIX_W'(BALL_SIZE - 1) <= PIX_W'(PAD_X_L + 3))
               && (ball_y_q + PIX_W'(BALL_SIZE - 1) >= pad_top_q)
               && (ball_y_q <= pad_top_q + PIX_W'(PAD_H - 1))
               && !dx_q[PIX_W-1];
    end

    // Per-frame game state update.
    always_comb begin
        pad_top_d   = pad_top_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        miss_tick_d = 1'b0;
        if (refr_tick) begin
            if ((btn == 2'b10) && (pad_top_q >= PIX_W'(PAD_V))) begin
                pad_top_d = pad_top_q - PIX_W'(PAD_V);
            end else if ((btn == 2'b01)
                      && (pad_top_q + PIX_W'(PAD_H - 1 + PAD_V) <= PIX_W'(V_VIS - 1))) begin
                pad_top_d = pad_top_q + PIX_W'(PAD_V);
            end

            if (ball_x_q >= PIX_W'(H_VIS - BALL_SIZE)) begin
                ball_x_d    = BALL_X_RST;
                ball_y_d    = BALL_Y_RST;
                dx_d        = BV_POS;
                dy_d        = BV_POS;
                miss_tick_d = 1'b1;
            end else begin
                if (ball_y_q <= BV_POS) begin
                    dy_d = BV_POS;
                end else if (ball_y_q + PIX_W'(BALL_SIZE - 1) >= PIX_W'(V_VIS - 1 - BALL_V)) begin
                    dy_d = BV_NEG;
                end
                if (ball_x_q <= PIX_W'(WALL_X_L + 3 + BALL_V)) begin
                    dx_d = BV_POS;
                end else if (pad_hit) begin
                    dx_d = BV_NEG;
                end
                ball_x_d = ball_x_q + dx_d;
                ball_y_d = ball_y_q + dy_d;
            end
        end
    end

    // Object masks on the current scan position; all rectangles inclusive.
    always_comb begin
        wall_on = (pixel_x >= PIX_W'(WALL_X_L)) && (pixel_x <= PIX_W'(WALL_X_L + 3));
        pad_on  = (pixel_x >= PIX_W'(PAD_X_L)) && (pixel_x <= PIX_W'(PAD_X_L + 3))
               && (pixel_y >= pad_top_q) && (pixel_y <= pad_top_q + PIX_W'(PAD_H - 1));
        ball_on = (pixel_x >= ball_x_q) && (pixel_x <= ball_x_q + PIX_W'(BALL_SIZE - 1))
               && (pixel_y >= ball_y_q) && (pixel_y <= ball_y_q + PIX_W'(BALL_SIZE - 1));
        rgb_d   = COL_BG;
        if (!video_on) begin
            rgb_d = COL_OFF;
        end else if (wall_on) begin
            rgb_d = COL_WALL;
        end else if (pad_on) begin
            rgb_d = COL_PAD;
        end else if (ball_on) begin
            rgb_d = COL_BALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pad_top_q   <= PAD_TOP_RST;
            ball_x_q    <= BALL_X_RST;
            ball_y_q    <= BALL_Y_RST;
            dx_q        <= BV_POS;
            dy_q        <= BV_POS;
            miss_tick_q <= 1'b0;
            rgb_q       <= COL_OFF;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            pad_top_q   <= pad_top_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            miss_tick_q <= miss_tick_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign miss_tick = miss_tick_q;

`ifdef PONG_MISS_CNT_EN
    logic [3:0] miss_cnt_q, miss_cnt_d;

    // Saturating miss count, aligned with the miss_tick pulse.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_tick_d && (miss_cnt_q != 4'd15)) begin
            miss_cnt_d = miss_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_cnt_q <= 4'd0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
`else
    assign miss_cnt = 4'd0;
`endif

endmodule

// File: doc/pong_graphics.md
Name: pong_graphics

Overview:
Pixel-generation stage placed directly downstream of the VGA sync generator. It consumes pixel_x, pixel_y, video_on, hsync and vsync, and drives a registered 12-bit RGB stream for the Pong screen: left wall, right paddle and a moving square ball. Paddle and ball state update once per frame on an internally detected refresh tick. Sync is delayed one clock so it stays aligned with RGB.

Parameters:
BALL_SIZE, 8, ball edge length in pixels
BALL_V, 2, ball speed per frame on each axis (px)
PAD_H, 72, paddle height (px)
PAD_V, 4, paddle speed per frame (px)
PAD_X_L, 600, paddle left column; paddle is 4 px wide (PAD_X_L..PAD_X_L+3)
WALL_X_L, 32, wall left column; wall is 4 px wide (WALL_X_L..WALL_X_L+3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_x  in  10  current column from sync stage
pixel_y  in  10  current row from sync stage
video_on  in  1  visible-area flag from sync stage
hsync_in  in  1  hsync from sync stage
vsync_in  in  1  vsync from sync stage
btn  in  2  btn[1]=paddle up, btn[0]=paddle down (already debounced, level)
rgb  out  12  {R[3:0],G[3:0],B[3:0]}, registered
hsync_out  out  1  hsync_in delayed 1 clk
vsync_out  out  1  vsync_in delayed 1 clk
miss_tick  out  1  1-clk pulse when the ball exits the right edge
miss_cnt  out  4  miss counter (see Optional Feature)

Behaviour:
- Reset (reset=0, async): rgb=0, hsync_out=1, vsync_out=1, miss_tick=0, miss_cnt=0, paddle_top=204, ball_x=320, ball_y=240, dx=+BALL_V, dy=+BALL_V, tick-detect register=0.
- refr_tick: 1-clk pulse generated on the first clk where (pixel_y==481 && pixel_x==0). Edge-detect the match against the registered match of the previous clk; pixel_x dwells several clks per pixel, but the pulse fires only once per frame.
- All position and velocity registers change only on refr_tick.
- Paddle, on refr_tick:
  - btn==2'b10 and paddle_top>=PAD_V: paddle_top -= PAD_V.
  - btn==2'b01 and paddle_top+PAD_H-1+PAD_V<=479: paddle_top += PAD_V.
  - btn==00 or 11, or the move would cross a screen edge: hold.
- Ball, on refr_tick, with velocity resolved first in this priority order, then position updated with the resolved velocity:
  1. Miss (ball_x>=640-BALL_SIZE): ball_x=320, ball_y=240, dx=dy=+BALL_V; miss_tick=1 for this clk. No other update.
  2. ball_y<=BALL_V: dy=+BALL_V. ball_y+BALL_SIZE-1>=479-BALL_V: dy=-BALL_V.
  3. ball_x<=WALL_X_L+3+BALL_V: dx=+BALL_V.
  4. Paddle hit: right edge (ball_x+BALL_SIZE-1) within [PAD_X_L, PAD_X_L+3], vertical overlap with [paddle_top, paddle_top+PAD_H-1], and dx>0: dx=-BALL_V.
  - Y and X rules apply independently, so a corner hit flips both.
- Position arithmetic:
  - 10-bit unsigned positions; velocity is added as 10-bit two's complement, mod 1024.
  - The bounds above guarantee no wrap occurs.
- Pixel output (1-clk latency from pixel_x/pixel_y/video_on):
  - video_on=0: rgb=12'h000.
  - Otherwise, priority wall 12'h00F > paddle 12'h0F0 > ball 12'hF00 > background 12'h888.
  - Object regions are inclusive rectangles.
- hsync_out/vsync_out: a plain 1-clk register of the inputs, matching rgb latency.
- Reset asserted mid-frame: all state returns to reset values immediately; normal operation resumes on the next refr_tick after release.

Optional Feature:
- Macro: PONG_MISS_CNT_EN.
- Defined: miss_cnt increments on each miss_tick and saturates at 15. It clears only on reset.
- Undefined: miss_cnt is tied to 4'd0 and no counter register exists. miss_tick behaves the same in both builds.

Decomposition:
- Package pong_pkg:
  - Screen constants: H_VIS=640, V_VIS=480, REFR_ROW=481.
  - Colour constants: COL_WALL, COL_PAD, COL_BALL, COL_BG, COL_OFF.
  - Reset positions: PAD_TOP_RST=204, BALL_X_RST=320, BALL_Y_RST=240.
- Sub-module frame_tick_gen: inputs clk, reset, pixel_x, pixel_y; output refr_tick. Holds the match register and edge detect.

Test Plan:
- Reset release, then a full frame with btn=00 -> exactly one refr_tick; after it, ball=(322,242) and paddle_top=204.
- btn=10 held for 60 frames -> paddle_top 204 -> 0 after 51 frames, then stays 0. btn=01 from 0 -> stops at 408 (408+71+4>479 blocks further moves).
- Force ball_y=472 with dy=+2 at refr_tick -> dy becomes -2 and ball_y=470. Force ball_x=36 with dx=-2 -> dx=+2 and ball_x=38.
- ball_x=592 (right edge 599) moving right with paddle_top=200, ball_y=230 -> after the tick right edge=601, so it is in paddle columns; on the next tick dx=-2 and ball_x=592.
- Paddle moved away, ball reaches x>=632 -> miss_tick pulses 1 clk, ball resets to (320,240). With PONG_MISS_CNT_EN, 17 misses leave miss_cnt=15; without it, miss_cnt=0.
- Pixel (34,100) with video_on=1 -> rgb=00F one clk later. (700,100) with video_on=0 -> rgb=000. hsync_in toggling -> hsync_out follows with a 1-clk delay.
